truth_table_reader: RTL

//  Sequential reader for small combinational gate networks. It sweeps the

---
 rtl/truth_table_reader_pkg.sv | 19 +
 rtl/truth_table_reader_classifier.sv | 22 ++
 rtl/truth_table_reader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/truth_table_reader_pkg.sv
// Shared FSM state codes and function-classification codes for truth_table_reader.
package truth_table_reader_pkg;

   localparam int unsigned STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] ST_SETTLE = 2'd1;
   localparam logic [STATE_W-1:0] ST_SAMPLE = 2'd2;
   localparam logic [STATE_W-1:0] ST_DONE   = 2'd3;

   localparam int unsigned FUNC_W = 4;
   localparam logic [FUNC_W-1:0] FUNC_UNKNOWN = 4'd0;
   localparam logic [FUNC_W-1:0] FUNC_AND     = 4'd1;
   localparam logic [FUNC_W-1:0] FUNC_OR      = 4'd2;
   localparam logic [FUNC_W-1:0] FUNC_NAND    = 4'd3;
   localparam logic [FUNC_W-1:0] FUNC_NOR     = 4'd4;
   localparam logic [FUNC_W-1:0] FUNC_XOR     = 4'd5;
   localparam logic [FUNC_W-1:0] FUNC_XNOR    = 4'd6;

endpackage

// File: rtl/truth_table_reader_classifier.sv
// func_classifier: maps a 2-input truth table (index {a,b}) to a known gate code.
module func_classifier
   import truth_table_reader_pkg::*;
(
   input  logic [3:0]        tbl,
   output logic [FUNC_W-1:0] func_id_c
);

   always_comb begin
      func_id_c = FUNC_UNKNOWN;
      case (tbl)
         4'b1000: func_id_c = FUNC_AND;
         4'b1110: func_id_c = FUNC_OR;
         4'b0111: func_id_c = FUNC_NAND;
         4'b0001: func_id_c = FUNC_NOR;
         4'b0110: func_id_c = FUNC_XOR;
         4'b1001: func_id_c = FUNC_XNOR;
         default: func_id_c = FUNC_UNKNOWN;
      endcase
   end

endmodule

// File: rtl/truth_table_reader.sv
// Sweeps drv through all input combinations, samples smp after SETTLE cycles, builds tbl.
// Optional self-compare against expect_tbl when TRUTH_TABLE_READER_CHECK_EN is defined.
module truth_table_reader
   import truth_table_reader_pkg::*;
#(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
`ifdef TRUTH_TABLE_READER_CHECK_EN
   input  logic [2**N_IN-1:0]   expect_tbl,
   output logic                 pass,
`endif
   output logic [N_IN-1:0]      drv,
   input  logic                 smp,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   tbl,
   output logic [FUNC_W-1:0]    func_id
);

   localparam int unsigned TBL_W = 2**N_IN;
   localparam int unsigned IDX_W = N_IN;
   localparam int unsigned CNT_W = $clog2(SETTLE + 1);
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(TBL_W - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [IDX_W-1:0]   drv_q, drv_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [TBL_W-1:0]   tbl_q, tbl_d;
   logic [FUNC_W-1:0]  func_id_q, func_id_d;
   logic [FUNC_W-1:0]  class_c;
`ifdef TRUTH_TABLE_READER_CHECK_EN
   logic [TBL_W-1:0]   expect_q, expect_d;
   logic               pass_q, pass_d;
`endif

   // Classify the table being completed so func_id is valid together with done.
   func_classifier u_classifier (
      .tbl       (4'(tbl_d)),
      .func_id_c (class_c)
   );

   always_comb begin
      state_d   = state_q;
      drv_d     = drv_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      tbl_d     = tbl_q;
      func_id_d = func_id_q;
`ifdef TRUTH_TABLE_READER_CHECK_EN
      expect_d  = expect_q;
      pass_d    = pass_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_SETTLE;
               drv_d     = '0;
               idx_d     = '0;
               cnt_d     = '0;
               tbl_d     = '0;
               func_id_d = FUNC_UNKNOWN;
               busy_d    = 1'b1;
`ifdef TRUTH_TABLE_READER_CHECK_EN
               expect_d  = expect_tbl;
               pass_d    = 1'b0;
`endif
            end
         end
         ST_SETTLE: begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            tbl_d[idx_q] = smp;
            if (idx_q == IDX_MAX) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               func_id_d = (N_IN == 2) ? class_c : FUNC_UNKNOWN;
`ifdef TRUTH_TABLE_READER_CHECK_EN
               pass_d    = (tbl_d == expect_q);
`endif
            end else begin
               state_d = ST_SETTLE;
               idx_d   = IDX_W'(idx_q + 1'b1);
               drv_d   = IDX_W'(idx_q + 1'b1);
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         drv_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tbl_q     <= '0;
         func_id_q <= FUNC_UNKNOWN;
`ifdef TRUTH_TABLE_READER_CHECK_EN
         expect_q  <= '0;
         pass_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         drv_q     <= drv_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         tbl_q     <= tbl_d;
         func_id_q <= func_id_d;
`ifdef TRUTH_TABLE_READER_CHECK_EN
         expect_q  <= expect_d;
         pass_q    <= pass_d;
`endif
      end
   end

   assign drv     = drv_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign tbl     = tbl_q;
   assign func_id = func_id_q;
`ifdef TRUTH_TABLE_READER_CHECK_EN
   assign pass    = pass_q;
`endif

endmodule
